// File: rtl/centroid_update_sequencer.sv
// Iteration-level sequencer for the k-means core.
// Each iteration it fetches the 8 new means in order and writes each one back
// to the centroid store. It feeds 0..6 into the convergence checker and uses
// the 8th to strobe the final evaluation. It then finishes (converged or
// iteration limit) or re-launches classification for another pass.
module centroid_update_sequencer #(
  parameter int dataWidth  = 91,
  parameter int iter_width = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [iter_width-1:0] max_iter,
  output logic                  busy,
  output logic                  done,
  output logic                  converged,
  output logic                  timed_out,
  output logic [iter_width-1:0] iter_count,
  output logic                  classify_req,
  input  logic                  classify_done,
  output logic                  means_req,
  output logic [2:0]            cent_num,
  input  logic                  means_valid,
  input  logic [dataWidth-1:0]  new_centroid,
  output logic                  conv_en,
  output logic                  conv_clr_n,
  input  logic                  conv_res_avail,
  input  logic                  has_converged,
  output logic                  cent_wr_en,
  output logic [2:0]            cent_wr_addr,
  output logic [dataWidth-1:0]  cent_wr_data
);

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    REQ,
    WAIT_RES,
    RECLASS,
    DONE
  } state_t;

  state_t                state_reg, state_next;
  logic [2:0]            index_reg, index_next;
  logic                  req_sent_reg, req_sent_next;
  logic                  converged_reg, converged_next;
  logic                  timed_out_reg, timed_out_next;
  logic [iter_width-1:0] iter_count_reg, iter_count_next;
  logic [iter_width-1:0] iter_inc;

  // Saturating increment so an unlimited run never wraps the counter.
  assign iter_inc = (&iter_count_reg) ? iter_count_reg
                                      : iter_count_reg + iter_width'(1);

  assign converged    = converged_reg;
  assign timed_out    = timed_out_reg;
  assign iter_count   = iter_count_reg;
  assign cent_wr_addr = index_reg;
  assign cent_wr_data = new_centroid;

  // State and result registers, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      index_reg      <= 3'd0;
      req_sent_reg   <= 1'b0;
      converged_reg  <= 1'b0;
      timed_out_reg  <= 1'b0;
      iter_count_reg <= '0;
    end else begin
      state_reg      <= state_next;
      index_reg      <= index_next;
      req_sent_reg   <= req_sent_next;
      converged_reg  <= converged_next;
      timed_out_reg  <= timed_out_next;
      iter_count_reg <= iter_count_next;
    end
  end

  // Next-state logic and per-state strobes.
  always_comb begin
    state_next      = state_reg;
    index_next      = index_reg;
    req_sent_next   = req_sent_reg;
    converged_next  = converged_reg;
    timed_out_next  = timed_out_reg;
    iter_count_next = iter_count_reg;
    busy            = 1'b0;
    done            = 1'b0;
    classify_req    = 1'b0;
    means_req       = 1'b0;
    cent_num        = 3'd0;
    conv_en         = 1'b0;
    conv_clr_n      = 1'b1;
    cent_wr_en      = 1'b0;

    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next      = CLEAR;
          iter_count_next = '0;
          converged_next  = 1'b0;
          timed_out_next  = 1'b0;
        end
      end

      CLEAR: begin
        busy       = 1'b1;
        conv_clr_n = 1'b0;
        index_next = 3'd0;
        state_next = REQ;
      end

      REQ: begin
        busy      = 1'b1;
        means_req = 1'b1;
        cent_num  = index_reg;
        if (means_valid) begin
          cent_wr_en = 1'b1;
          if (index_reg == 3'd7) begin
            // Last centroid doubles as the final-evaluation strobe.
            conv_clr_n = 1'b0;
            state_next = WAIT_RES;
          end else begin
            conv_en    = 1'b1;
            index_next = index_reg + 3'd1;
          end
        end
      end

      WAIT_RES: begin
        busy     = 1'b1;
        cent_num = 3'd7;
        if (conv_res_avail) begin
          iter_count_next = iter_inc;
          // Convergence takes priority over hitting the limit.
          if (has_converged) begin
            converged_next = 1'b1;
            state_next     = DONE;
          end else if ((max_iter != '0) && (iter_inc == max_iter)) begin
            timed_out_next = 1'b1;
            state_next     = DONE;
          end else begin
            req_sent_next = 1'b0;
            state_next    = RECLASS;
          end
        end
      end

      RECLASS: begin
        busy          = 1'b1;
        classify_req  = ~req_sent_reg;
        req_sent_next = 1'b1;
        if (classify_done) begin
          state_next = CLEAR;
        end
      end

      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase

    // A reset mid-iteration must not let a write or strobe slip through
    // in the cycle it is asserted.
    if (!rst_n) begin
      busy         = 1'b0;
      done         = 1'b0;
      classify_req = 1'b0;
      means_req    = 1'b0;
      cent_num     = 3'd0;
      conv_en      = 1'b0;
      conv_clr_n   = 1'b1;
      cent_wr_en   = 1'b0;
    end
  end

endmodule
